// File: rtl/ofdm_pkg.sv
// ofdm_pkg: shared sizes and FSM encoding for the receive-side cyclic-prefix remover.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

package ofdm_pkg;

  localparam int N_FFT = 64;
  localparam int N_CP  = 16;
  localparam int DW    = 32;
  localparam int SYM_W = N_FFT * DW;
  localparam int IDX_W = $clog2(N_FFT);

  typedef enum logic [1:0] {
    CP   = 2'd0,
    DATA = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ofdm_sym_buffer.sv
// ofdm_sym_buffer: N_FFT-lane assembly register pair, one real/imag lane written per enabled cycle.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module ofdm_sym_buffer
  import ofdm_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] lane,
  input  logic [DW-1:0]    wr_real,
  input  logic [DW-1:0]    wr_imag,
  output logic [SYM_W-1:0] buf_real,
  output logic [SYM_W-1:0] buf_imag
);

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_real <= '0;
      buf_imag <= '0;
    end else if (we) begin
      buf_real[DW*lane +: DW] <= wr_real;
      buf_imag[DW*lane +: DW] <= wr_imag;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ofdm_cp_remover.sv
// ofdm_cp_remover: drops the cyclic prefix and assembles the body into one parallel FFT word.
// Optional in_sof resynchronisation is built when OFDM_CP_SOF_SYNC_EN is defined. Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module ofdm_cp_remover
  import ofdm_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  logic [DW-1:0]    in_real,
  input  logic [DW-1:0]    in_imag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SYM_W-1:0] out_real,
  output logic [SYM_W-1:0] out_imag,
  output logic             sync_err,
  output logic [15:0]      sym_count
);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] cnt, cnt_nxt;
  logic             beat, consume, out_free, sof_beat;
  logic             buf_we, load_out, load_from_input;
  logic [SYM_W-1:0] buf_real, buf_imag, load_real, load_imag;

  assign in_ready = (state != HOLD);
  assign beat     = in_valid && in_ready;
  assign consume  = out_valid && out_ready;
  assign out_free = !out_valid || out_ready;

`ifdef OFDM_CP_SOF_SYNC_EN
  logic sync_err_q;

  assign sof_beat = beat && in_sof;

  // Any marker that does not land on prefix index 0 means we lost alignment.
  always_ff @(posedge clk) begin
    if (reset) sync_err_q <= 1'b0;
    else       sync_err_q <= sof_beat && !(state == CP && cnt == '0);
  end

  assign sync_err = sync_err_q;
`else
  logic unused_sof;

  assign unused_sof = in_sof;
  assign sof_beat   = 1'b0;
  assign sync_err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CP;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    buf_we          = 1'b0;
    load_out        = 1'b0;
    load_from_input = 1'b0;
    if (sof_beat) begin
      // The marked sample is itself prefix index 0.
      state_nxt = CP;
      cnt_nxt   = IDX_W'(1);
    end else begin
      case (state)
        CP: begin
          if (beat) begin
            if (cnt == IDX_W'(N_CP - 1)) begin
              state_nxt = DATA;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (beat) begin
            buf_we = 1'b1;
            if (cnt == IDX_W'(N_FFT - 1)) begin
              cnt_nxt = '0;
              if (out_free) begin
                load_out        = 1'b1;
                load_from_input = 1'b1;
                state_nxt       = CP;
              end else begin
                state_nxt = HOLD;
              end
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (consume) begin
            load_out  = 1'b1;
            state_nxt = CP;
          end
        end
        default: state_nxt = CP;
      endcase
    end
  end

  ofdm_sym_buffer u_buf (
    .clk      (clk),
    .reset    (reset),
    .we       (buf_we),
    .lane     (cnt),
    .wr_real  (in_real),
    .wr_imag  (in_imag),
    .buf_real (buf_real),
    .buf_imag (buf_imag)
  );

  // Direct load bypasses the buffer for the last lane, which is only being written this cycle.
  always_comb begin
    load_real = buf_real;
    load_imag = buf_imag;
    if (load_from_input) begin
      load_real[SYM_W-1 -: DW] = in_real;
      load_imag[SYM_W-1 -: DW] = in_imag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
      sym_count <= '0;
    end else begin
      if (consume) sym_count <= sym_count + 16'd1;
      if (load_out) begin
        out_valid <= 1'b1;
        out_real  <= load_real;
        out_imag  <= load_imag;
      end else if (consume) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ofdm_cp_remover.sv
// tb_ofdm_cp_remover: directed stimulus with a beat-position reference model and symbol scoreboard.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_ofdm_cp_remover;
  import ofdm_pkg::*;

  logic             clk = 1'b0;
  logic             reset, in_valid, in_ready, in_sof, out_valid, out_ready, sync_err;
  logic [DW-1:0]    in_real, in_imag;
  logic [SYM_W-1:0] out_real, out_imag;
  logic [15:0]      sym_count;

  always #5 clk = ~clk;

  ofdm_cp_remover dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sof    (in_sof),
    .in_real   (in_real),
    .in_imag   (in_imag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_real  (out_real),
    .out_imag  (out_imag),
    .sync_err  (sync_err),
    .sym_count (sym_count)
  );

  int total = 0;
  int bad   = 0;
  int cycle = 0;
  int exp_sym = 0;
  int mpos = 0;
  int stalls = 0;
  logic [SYM_W-1:0] m_re = '0;
  logic [SYM_W-1:0] m_im = '0;
  logic [SYM_W-1:0] exp_re_q[$];
  logic [SYM_W-1:0] exp_im_q[$];
  int pop_cycle_q[$];

  always @(posedge clk) cycle++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_sym(input string tag, input logic [SYM_W-1:0] obs, input logic [SYM_W-1:0] exp);
    int l;
    l = 0;
    total++;
    assert (obs === exp) else begin
      bad++;
      for (int k = N_FFT - 1; k >= 0; k--)
        if (obs[DW*k +: DW] !== exp[DW*k +: DW]) l = k;
      $error("FAIL %s lane=%0d observed=%h expected=%h", tag, l, obs[DW*l +: DW], exp[DW*l +: DW]);
    end
  endtask

  // Scoreboard: every handshake must match the oldest predicted symbol.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      chk("symbol_pending", 64'(exp_re_q.size() != 0), 64'd1);
      if (exp_re_q.size() != 0) begin
        chk_sym("sym_real", out_real, exp_re_q.pop_front());
        chk_sym("sym_imag", out_imag, exp_im_q.pop_front());
      end
      exp_sym = (exp_sym + 1) & 16'hFFFF;
      pop_cycle_q.push_back(cycle);
    end
  end

  // Reference: position of each beat in the 80-sample symbol frame.
  task automatic model_beat(input logic [DW-1:0] re, input logic [DW-1:0] im,
                            input logic sof, output logic e);
    int pos;
    e   = 1'b0;
    pos = mpos;
`ifdef OFDM_CP_SOF_SYNC_EN
    if (sof) begin
      e   = (mpos != 0);
      pos = 0;
    end
`else
    if (sof) e = 1'b0;
`endif
    if (pos >= N_CP) begin
      m_re[DW*(pos-N_CP) +: DW] = re;
      m_im[DW*(pos-N_CP) +: DW] = im;
    end
    if (pos == N_CP + N_FFT - 1) begin
      exp_re_q.push_back(m_re);
      exp_im_q.push_back(m_im);
      mpos = 0;
    end else begin
      mpos = pos + 1;
    end
  endtask

  task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im, input logic sof);
    int w;
    logic e;
    w = 0;
    in_valid = 1'b1;
    in_real  = re;
    in_imag  = im;
    in_sof   = sof;
    while (!in_ready && w < 300) begin
      @(posedge clk); #1;
      w++;
      stalls++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      return;
    end
    model_beat(re, im, sof, e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    chk("sync_err", 64'(sync_err), 64'(e));
  endtask

  function automatic logic [DW-1:0] pre_val(input int s, input int i);
    return 32'hDEAD0000 | DW'((s & 8'hFF) << 8) | DW'(i);
  endfunction

  function automatic logic [DW-1:0] body_val(input int s, input int k);
    return 32'h3F800000 + DW'(s << 16) + DW'(k);
  endfunction

  task automatic send_symbol(input int s, input int nbody, input logic sof_first);
    for (int i = 0; i < N_CP; i++)
      send(pre_val(s, i), ~pre_val(s, i), sof_first && (i == 0));
    for (int k = 0; k < nbody; k++)
      send(body_val(s, k), ~body_val(s, k), 1'b0);
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (exp_re_q.size() != 0 && w < 500) begin
      @(posedge clk); #1;
      w++;
    end
    chk("drain", 64'(exp_re_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_re_q.delete();
    exp_im_q.delete();
    mpos    = 0;
    exp_sym = 0;
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_real   = '0;
    in_imag   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sym_count", 64'(sym_count), 64'd0);
    chk("rst_sync_err", 64'(sync_err), 64'd0);
    chk_sym("rst_out_real", out_real, '0);
    chk_sym("rst_out_imag", out_imag, '0);
    reset = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Single symbol: output appears the cycle after the 80th beat.
    send_symbol(0, N_FFT, 1'b0);
    chk("single_latency", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    chk("single_cleared", 64'(out_valid), 64'd0);
    chk("single_count", 64'(sym_count), 64'd1);

    // Three back-to-back symbols.
    stalls = 0;
    for (int s = 1; s <= 3; s++) send_symbol(s, N_FFT, 1'b0);
    wait_drain();
    chk("b2b_no_stall", 64'(stalls), 64'd0);
    n = pop_cycle_q.size();
    chk("b2b_spacing_a", 64'(pop_cycle_q[n-1] - pop_cycle_q[n-2]), 64'd80);
    chk("b2b_spacing_b", 64'(pop_cycle_q[n-2] - pop_cycle_q[n-3]), 64'd80);
    chk("b2b_count", 64'(sym_count), 64'd4);

    // Back-pressure: second symbol end lands in HOLD.
    out_ready = 1'b0;
    send_symbol(4, N_FFT, 1'b0);
    send_symbol(5, N_FFT, 1'b0);
    chk("hold_in_ready", 64'(in_ready), 64'd0);
    chk("hold_out_valid", 64'(out_valid), 64'd1);
    chk_sym("hold_stable_0", out_real, exp_re_q[0]);
    repeat (3) @(posedge clk);
    #1;
    chk_sym("hold_stable_1", out_real, exp_re_q[0]);
    chk("hold_in_ready_1", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_exit_ready", 64'(in_ready), 64'd1);
    chk("hold_exit_valid", 64'(out_valid), 64'd1);
    chk_sym("hold_second_loaded", out_real, exp_re_q[0]);
    chk("hold_count_mid", 64'(sym_count), 64'd5);
    wait_drain();
    @(posedge clk); #1;
    chk("hold_count", 64'(sym_count), 64'd6);

    // Start-of-symbol marker at body beat 30 of a truncated symbol.
    send_symbol(10, 30, 1'b0);
    send_symbol(11, N_FFT, 1'b1);
    wait_drain();
    @(posedge clk); #1;
    chk("sof_count", 64'(sym_count), 64'd7);
    chk("sof_count_model", 64'(sym_count), 64'(exp_sym));

    // Reset while holding a pending symbol.
    do_reset();
    out_ready = 1'b0;
    send_symbol(20, N_FFT, 1'b0);
    send_symbol(21, N_FFT, 1'b0);
    chk("rh_in_hold", 64'(in_ready), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_re_q.delete();
    exp_im_q.delete();
    mpos    = 0;
    exp_sym = 0;
    chk("rh_out_valid", 64'(out_valid), 64'd0);
    chk("rh_sym_count", 64'(sym_count), 64'd0);
    chk("rh_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    send_symbol(22, N_FFT, 1'b0);
    wait_drain();
    @(posedge clk); #1;
    chk("rh_recover_count", 64'(sym_count), 64'd1);

    repeat (5) @(posedge clk);
    #1;
    chk("final_queue_empty", 64'(exp_re_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
